// File: rtl/control_unit.sv
// Multicycle control FSM for the 8-bit CPU datapath.
// Handshake note: there is no valid/ready traffic here; every output is a
// per-cycle strobe decoded from the current state (plus the Z flag in BR),
// and the datapath acts on it at the next rising edge.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] IrToCU,
  input  logic [4:0] DiToCU,
  input  logic [2:0] CznToCU,
  output logic       pcInc,
  output logic       pcLoadEn,
  output logic       diLoadEn,
  output logic       reg1Or2,
  output logic       PcOrTR,
  output logic       regOrMem,
  output logic       RegBOr0,
  output logic       RegAOr0,
  output logic       memoryReadEn,
  output logic       memoryWriteEn,
  output logic       irWriteEn,
  output logic       trWriteEn,
  output logic       bRegWriteEn,
  output logic       aRegWriteEn,
  output logic       aluResWriteEn,
  output logic       accumulatorWriteEn,
  output logic       ldCZN,
  output logic [1:0] aluOpControl,
  output logic [3:0] state,
  output logic       instrDone
);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_JMP   = 3'b010;
  localparam logic [2:0] OP_JZ    = 3'b011;
  localparam logic [2:0] OP_ADDM  = 3'b100;
  localparam logic [2:0] OP_ANDM  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;
  localparam logic [2:0] OP_REG   = 3'b111;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    M_EX   = 4'd2,
    REG_B  = 4'd3,
    REG_A  = 4'd4,
    ALU    = 4'd5,
    WB     = 4'd6,
    ST_A   = 4'd7,
    ST_ALU = 4'd8,
    ST_WR  = 4'd9,
    BR     = 4'd10
  } state_t;

  state_t     state_q;
  state_t     state_n;
  logic [2:0] opcode;

  assign opcode = IrToCU[3:1];
  assign state  = state_q;

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_n;
  end

  // Next-state and Moore output decode; everything is forced to 0 under reset.
  always_comb begin
    state_n            = FETCH;
    pcInc              = 1'b0;
    pcLoadEn           = 1'b0;
    diLoadEn           = 1'b0;
    reg1Or2            = 1'b0;
    PcOrTR             = 1'b0;
    regOrMem           = 1'b0;
    RegBOr0            = 1'b0;
    RegAOr0            = 1'b0;
    memoryReadEn       = 1'b0;
    memoryWriteEn      = 1'b0;
    irWriteEn          = 1'b0;
    trWriteEn          = 1'b0;
    bRegWriteEn        = 1'b0;
    aRegWriteEn        = 1'b0;
    aluResWriteEn      = 1'b0;
    accumulatorWriteEn = 1'b0;
    ldCZN              = 1'b0;
    aluOpControl       = ALU_ADD;
    instrDone          = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          PcOrTR       = 1'b1;
          memoryReadEn = 1'b1;
          irWriteEn    = 1'b1;
          pcInc        = 1'b1;
          state_n      = DECODE;
        end
        DECODE: begin
          diLoadEn = 1'b1;
          if (opcode == OP_NOP) begin
            instrDone = 1'b1;
            state_n   = FETCH;
          end else if (opcode == OP_REG) begin
            state_n = REG_B;
          end else begin
            // Second instruction byte goes into TR as the address low byte.
            PcOrTR       = 1'b1;
            memoryReadEn = 1'b1;
            trWriteEn    = 1'b1;
            pcInc        = 1'b1;
            if (opcode == OP_STORE)                         state_n = ST_A;
            else if (opcode == OP_JMP || opcode == OP_JZ)   state_n = BR;
            else                                            state_n = M_EX;
          end
        end
        M_EX: begin
          memoryReadEn = 1'b1;
          bRegWriteEn  = 1'b1;
          aRegWriteEn  = 1'b1;
          state_n      = ALU;
        end
        REG_B: begin
          regOrMem    = 1'b1;
          bRegWriteEn = 1'b1;
          state_n     = REG_A;
        end
        REG_A: begin
          reg1Or2     = 1'b1;
          aRegWriteEn = 1'b1;
          state_n     = ALU;
        end
        ALU: begin
          aluResWriteEn = 1'b1;
          ldCZN         = 1'b1;
          // LOAD and MOV pass B through by zeroing the other ALU input.
          if (opcode == OP_LOAD || (opcode == OP_REG && !DiToCU[4])) RegAOr0 = 1'b1;
          if (opcode == OP_ANDM) aluOpControl = ALU_AND;
          state_n = WB;
        end
        WB: begin
          accumulatorWriteEn = 1'b1;
          instrDone          = 1'b1;
          reg1Or2            = (opcode == OP_REG);
          state_n            = FETCH;
        end
        ST_A: begin
          aRegWriteEn = 1'b1;
          state_n     = ST_ALU;
        end
        ST_ALU: begin
          RegBOr0       = 1'b1;
          aluResWriteEn = 1'b1;
          state_n       = ST_WR;
        end
        ST_WR: begin
          memoryWriteEn = 1'b1;
          instrDone     = 1'b1;
          state_n       = FETCH;
        end
        BR: begin
          instrDone = 1'b1;
          pcLoadEn  = (opcode == OP_JMP) ? 1'b1 : CznToCU[1];
          state_n   = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle state and packed-output checks.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [3:0] IrToCU;
  logic [4:0] DiToCU;
  logic [2:0] CznToCU;
  logic       pcInc, pcLoadEn, diLoadEn, reg1Or2, PcOrTR, regOrMem, RegBOr0, RegAOr0;
  logic       memoryReadEn, memoryWriteEn, irWriteEn, trWriteEn, bRegWriteEn, aRegWriteEn;
  logic       aluResWriteEn, accumulatorWriteEn, ldCZN, instrDone;
  logic [1:0] aluOpControl;
  logic [3:0] state;

  int total_cnt;
  int bad_cnt;

  // Output bit positions in the packed observation vector.
  localparam logic [19:0] O_PCINC = 20'h1 << 19;
  localparam logic [19:0] O_PCLD  = 20'h1 << 18;
  localparam logic [19:0] O_DILD  = 20'h1 << 17;
  localparam logic [19:0] O_R12   = 20'h1 << 16;
  localparam logic [19:0] O_PCTR  = 20'h1 << 15;
  localparam logic [19:0] O_ROM   = 20'h1 << 14;
  localparam logic [19:0] O_B0    = 20'h1 << 13;
  localparam logic [19:0] O_A0    = 20'h1 << 12;
  localparam logic [19:0] O_MRD   = 20'h1 << 11;
  localparam logic [19:0] O_MWR   = 20'h1 << 10;
  localparam logic [19:0] O_IRWE  = 20'h1 << 9;
  localparam logic [19:0] O_TRWE  = 20'h1 << 8;
  localparam logic [19:0] O_BWE   = 20'h1 << 7;
  localparam logic [19:0] O_AWE   = 20'h1 << 6;
  localparam logic [19:0] O_ARWE  = 20'h1 << 5;
  localparam logic [19:0] O_ACCWE = 20'h1 << 4;
  localparam logic [19:0] O_CZN   = 20'h1 << 3;
  localparam logic [19:0] O_AND   = 20'h1 << 1;
  localparam logic [19:0] O_DONE  = 20'h1 << 0;

  localparam logic [19:0] E_FETCH  = O_PCINC | O_PCTR | O_MRD | O_IRWE;
  localparam logic [19:0] E_DEC_M  = O_DILD | O_PCTR | O_MRD | O_TRWE | O_PCINC;
  localparam logic [19:0] E_DEC_N  = O_DILD | O_DONE;
  localparam logic [19:0] E_DEC_R  = O_DILD;
  localparam logic [19:0] E_MEX    = O_MRD | O_BWE | O_AWE;
  localparam logic [19:0] E_ALU_P  = O_ARWE | O_CZN | O_A0;
  localparam logic [19:0] E_ALU_AD = O_ARWE | O_CZN;
  localparam logic [19:0] E_ALU_AN = O_ARWE | O_CZN | O_AND;
  localparam logic [19:0] E_WB_M   = O_ACCWE | O_DONE;
  localparam logic [19:0] E_WB_R   = O_ACCWE | O_DONE | O_R12;
  localparam logic [19:0] E_REGB   = O_ROM | O_BWE;
  localparam logic [19:0] E_REGA   = O_R12 | O_AWE;
  localparam logic [19:0] E_STA    = O_AWE;
  localparam logic [19:0] E_STALU  = O_B0 | O_ARWE;
  localparam logic [19:0] E_STWR   = O_MWR | O_DONE;
  localparam logic [19:0] E_BR_T   = O_DONE | O_PCLD;
  localparam logic [19:0] E_BR_N   = O_DONE;

  logic [19:0] outs;
  assign outs = {pcInc, pcLoadEn, diLoadEn, reg1Or2, PcOrTR, regOrMem, RegBOr0, RegAOr0,
                 memoryReadEn, memoryWriteEn, irWriteEn, trWriteEn, bRegWriteEn, aRegWriteEn,
                 aluResWriteEn, accumulatorWriteEn, ldCZN, aluOpControl, instrDone};

  control_unit dut (
    .clk(clk), .rst(rst), .IrToCU(IrToCU), .DiToCU(DiToCU), .CznToCU(CznToCU),
    .pcInc(pcInc), .pcLoadEn(pcLoadEn), .diLoadEn(diLoadEn), .reg1Or2(reg1Or2),
    .PcOrTR(PcOrTR), .regOrMem(regOrMem), .RegBOr0(RegBOr0), .RegAOr0(RegAOr0),
    .memoryReadEn(memoryReadEn), .memoryWriteEn(memoryWriteEn), .irWriteEn(irWriteEn),
    .trWriteEn(trWriteEn), .bRegWriteEn(bRegWriteEn), .aRegWriteEn(aRegWriteEn),
    .aluResWriteEn(aluResWriteEn), .accumulatorWriteEn(accumulatorWriteEn), .ldCZN(ldCZN),
    .aluOpControl(aluOpControl), .state(state), .instrDone(instrDone)
  );

  // Clock and reset stimulus.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle (inputs already applied), then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] es, input logic [19:0] eo);
    #1;
    check_val({tag, "_state"}, {28'd0, state}, {28'd0, es});
    check_val({tag, "_outs"},  {12'd0, outs},  {12'd0, eo});
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst     = 1'b1;
    IrToCU  = 4'b1100;
    DiToCU  = 5'd0;
    CznToCU = 3'b000;
    @(posedge clk); #1;
    cyc("rst_hold", 4'd0, 20'd0);
    rst = 1'b0;

    // LOAD
    IrToCU = 4'b0000; DiToCU = 5'b00011; CznToCU = 3'b111;
    cyc("ld_fetch", 4'd0, E_FETCH);
    cyc("ld_dec",   4'd1, E_DEC_M);
    cyc("ld_mex",   4'd2, E_MEX);
    cyc("ld_alu",   4'd5, E_ALU_P);
    cyc("ld_wb",    4'd6, E_WB_M);

    // STORE: no ldCZN anywhere
    IrToCU = 4'b0010; CznToCU = 3'b010;
    cyc("st_fetch", 4'd0, E_FETCH);
    cyc("st_dec",   4'd1, E_DEC_M);
    cyc("st_a",     4'd7, E_STA);
    cyc("st_alu",   4'd8, E_STALU);
    cyc("st_wr",    4'd9, E_STWR);

    // JZ taken
    IrToCU = 4'b0110; CznToCU = 3'b000;
    cyc("jzt_fetch", 4'd0, E_FETCH);
    cyc("jzt_dec",   4'd1, E_DEC_M);
    CznToCU = 3'b010;
    cyc("jzt_br",    4'd10, E_BR_T);

    // JZ not taken (other flags set, Z clear)
    CznToCU = 3'b101;
    cyc("jzn_fetch", 4'd0, E_FETCH);
    cyc("jzn_dec",   4'd1, E_DEC_M);
    cyc("jzn_br",    4'd10, E_BR_N);

    // JMP ignores Z
    IrToCU = 4'b0101; CznToCU = 3'b000;
    cyc("jmp_fetch", 4'd0, E_FETCH);
    cyc("jmp_dec",   4'd1, E_DEC_M);
    cyc("jmp_br",    4'd10, E_BR_T);

    // Register ADD
    IrToCU = 4'b1111; DiToCU = 5'b10110;
    cyc("radd_fetch", 4'd0, E_FETCH);
    cyc("radd_dec",   4'd1, E_DEC_R);
    cyc("radd_regb",  4'd3, E_REGB);
    cyc("radd_rega",  4'd4, E_REGA);
    cyc("radd_alu",   4'd5, E_ALU_AD);
    cyc("radd_wb",    4'd6, E_WB_R);

    // Register MOV passes B through
    IrToCU = 4'b1110; DiToCU = 5'b00110;
    cyc("mov_fetch", 4'd0, E_FETCH);
    cyc("mov_dec",   4'd1, E_DEC_R);
    cyc("mov_regb",  4'd3, E_REGB);
    cyc("mov_rega",  4'd4, E_REGA);
    cyc("mov_alu",   4'd5, E_ALU_P);
    cyc("mov_wb",    4'd6, E_WB_R);

    // NOP back-to-back with ANDM
    IrToCU = 4'b1100;
    cyc("nop_fetch", 4'd0, E_FETCH);
    cyc("nop_dec",   4'd1, E_DEC_N);
    IrToCU = 4'b1010; DiToCU = 5'b00001;
    cyc("andm_fetch", 4'd0, E_FETCH);
    cyc("andm_dec",   4'd1, E_DEC_M);
    cyc("andm_mex",   4'd2, E_MEX);
    cyc("andm_alu",   4'd5, E_ALU_AN);
    cyc("andm_wb",    4'd6, E_WB_M);

    // ADDM
    IrToCU = 4'b1001;
    cyc("addm_fetch", 4'd0, E_FETCH);
    cyc("addm_dec",   4'd1, E_DEC_M);
    cyc("addm_mex",   4'd2, E_MEX);
    cyc("addm_alu",   4'd5, E_ALU_AD);
    cyc("addm_wb",    4'd6, E_WB_M);

    // Reset held two cycles starting in the ALU state of a LOAD
    IrToCU = 4'b0000;
    cyc("rl_fetch", 4'd0, E_FETCH);
    cyc("rl_dec",   4'd1, E_DEC_M);
    cyc("rl_mex",   4'd2, E_MEX);
    rst = 1'b1;
    cyc("rl_rst0",  4'd5, 20'd0);
    cyc("rl_rst1",  4'd0, 20'd0);
    rst = 1'b0;
    cyc("rl_post",  4'd0, E_FETCH);
    cyc("rl_dec2",  4'd1, E_DEC_M);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle controller that drives the 8-bit/13-bit-address CPU datapath from the other side of its control/status interface.
- Consumes the opcode nibble, the latched DI field and the CZN flags; produces every mux select, register write enable and memory strobe.
- It is a Moore FSM, except for the single flag-dependent branch strobe. It sits beside the datapath in the CPU top.

Parameters:
ALU_ADD, 2'b00, aluOpControl code for result = aluIn1 + aluIn2 (carry-in ignored)
ALU_AND, 2'b01, aluOpControl code for bitwise AND

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active high
IrToCU  in  4  ir[7:4]; opcode = IrToCU[3:1]
DiToCU  in  5  DI register contents
CznToCU  in  3  flags {N,Z,C}: [2]=N, [1]=Z, [0]=C
pcInc  out  1  PC <= PC+1
pcLoadEn  out  1  PC <= TR
diLoadEn  out  1  DI <= ir[4:0]
reg1Or2  out  1  register address: 0 = DI[1:0], 1 = DI[3:2]
PcOrTR  out  1  memory address: 0 = TR, 1 = PC
regOrMem  out  1  B input: 0 = memory, 1 = register file
RegBOr0  out  1  ALU in1: 0 = B, 1 = zero
RegAOr0  out  1  ALU in2: 0 = A, 1 = zero
memoryReadEn, memoryWriteEn  out  1 each  memory strobes; read data is valid in the same cycle
irWriteEn, trWriteEn, bRegWriteEn, aRegWriteEn, aluResWriteEn, accumulatorWriteEn, ldCZN  out  1 each  write enables
aluOpControl  out  2  ALU operation
state  out  4  current FSM state (debug/verification)
instrDone  out  1  high for the last cycle of each instruction

Behaviour:
- Reset: state <= FETCH. While rst=1, every output is 0, including the combinational decode of the FETCH state. Reset mid-instruction abandons the instruction with no partial write after that edge.
- Unlisted outputs are 0 in every state.
- aluOpControl defaults to ALU_ADD.
- Instruction formats:
  - opcode 000 LOAD, 001 STORE, 010 JMP, 011 JZ, 100 ADDM, 101 ANDM: two bytes. Address = {ir[4:0], byte2}. Register operand = R[DI[1:0]], so the low address bits double as the register select.
  - 111 register form: one byte. DI[3:2] = dest, DI[1:0] = src. DI[4]=0 is MOV, DI[4]=1 is ADD (dest <= dest+src).
  - 110: NOP.
- States and transitions:
  - FETCH: PcOrTR=1, memoryReadEn, irWriteEn, pcInc. Next: DECODE.
  - DECODE: diLoadEn always.
    - Opcode 110: instrDone, next FETCH.
    - Opcode 111: next REG_B.
    - Otherwise: PcOrTR=1, memoryReadEn, trWriteEn, pcInc. Next:
      - LOAD/ADDM/ANDM: M_EX
      - STORE: ST_A
      - JMP/JZ: BR
  - M_EX: PcOrTR=0, memoryReadEn, regOrMem=0, bRegWriteEn, reg1Or2=0, aRegWriteEn. Next: ALU.
  - REG_B: reg1Or2=0, regOrMem=1, bRegWriteEn. Next: REG_A.
  - REG_A: reg1Or2=1, aRegWriteEn. Next: ALU.
  - ALU: aluResWriteEn, ldCZN. Next: WB.
    - LOAD or MOV: RegAOr0=1, ALU_ADD.
    - ADDM or register ADD: ALU_ADD.
    - ANDM: ALU_AND.
  - WB: accumulatorWriteEn, instrDone. reg1Or2 = 1 for register form, 0 for memory form. Next: FETCH.
  - ST_A: reg1Or2=0, aRegWriteEn. Next: ST_ALU.
  - ST_ALU: RegBOr0=1, ALU_ADD, aluResWriteEn; ldCZN=0. Next: ST_WR.
  - ST_WR: PcOrTR=0, memoryWriteEn, instrDone. Next: FETCH.
  - BR: instrDone. pcLoadEn=1 for JMP; pcLoadEn=CznToCU[1] for JZ (sampled in BR). Next: FETCH.
- Latency in cycles:
  - NOP 2
  - JMP/JZ 3
  - LOAD/ADDM/ANDM/STORE 5
  - register form 6
- Opcode is re-read from IrToCU in every state; IR is not written outside FETCH.
- Flags change only in the ALU state; STORE and branches preserve CZN.
- pcInc and pcLoadEn are never asserted together.
- Exactly one of memoryReadEn/memoryWriteEn is asserted in any cycle that drives memory.
- state encoding:
  - FETCH 0, DECODE 1, M_EX 2, REG_B 3, REG_A 4
  - ALU 5, WB 6, ST_A 7, ST_ALU 8, ST_WR 9, BR 10
  - Unused codes go to FETCH on the next cycle with outputs 0.

Test Plan:
- Reset: hold rst 2 cycles mid-ALU state -> all outputs 0 during rst; state=0 the cycle after release; the next FETCH asserts memoryReadEn, irWriteEn, pcInc, PcOrTR=1.
- LOAD (IrToCU=4'b0000): state sequence 0,1,2,5,6 -> WB has accumulatorWriteEn=1, reg1Or2=0; the ALU state has RegAOr0=1, aluOpControl=00, ldCZN=1; instrDone only in WB.
- STORE (IrToCU=4'b0010): sequence 0,1,7,8,9 -> ST_WR has memoryWriteEn=1, PcOrTR=0; ldCZN stays 0 for all 5 cycles.
- JZ (IrToCU=4'b0110): CznToCU=3'b010 -> pcLoadEn=1 in BR. CznToCU=3'b000 -> pcLoadEn=0. Both paths take 3 cycles.
- Register ADD (IrToCU=4'b1111, DiToCU=5'b10110): sequence 0,1,3,4,5,6 -> REG_B reg1Or2=0/regOrMem=1; REG_A reg1Or2=1; ALU aluOpControl=00 with RegAOr0=0; WB reg1Or2=1.
- NOP back-to-back with ANDM (IrToCU=4'b1100 then 4'b1010) -> NOP completes in 2 cycles; ANDM ALU state drives aluOpControl=01 with ldCZN=1.
